// File: rtl/simeck_enc_sequencer.sv
// Load/round/save sequencer feeding the Simeck encryptor datapath.
// Optional macro SIMECK_SEQ_BACKPRESSURE_EN: DONE waits for done_ready instead of pulsing.
module simeck_enc_sequencer #(
  parameter int DATAW    = 16,
  parameter int ROUNDS   = 32,
  parameter int KEYWORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [2*DATAW-1:0]           plaintext,
  input  logic [KEYWORDS*DATAW-1:0]    key_in,
  output logic [DATAW-1:0]             data,
  output logic [DATAW-1:0]             key,
  output logic                         dctr,
  output logic                         kctr,
  output logic                         lfsrset,
  output logic                         shiftregReset,
  output logic                         save,
  output logic                         done_valid,
  input  logic                         done_ready,
  output logic [$clog2(ROUNDS+1)-1:0]  round
);

  localparam int MAXC = (KEYWORDS > ROUNDS) ? KEYWORDS - 1 : ROUNDS - 1;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam int RW   = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAXC);
  localparam logic [CW-1:0] LOAD_LAST = CW'(KEYWORDS - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SAVE, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d, cnt_inc;
  logic [2*DATAW-1:0]          pt_q, pt_d;
  logic [KEYWORDS*DATAW-1:0]   key_q, key_d;
  logic                        save_q, save_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      save_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      save_q  <= save_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_inc;
    pt_d    = pt_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_valid) begin
          state_d = S_LOAD;
          pt_d    = plaintext;
          key_d   = key_in;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = S_SAVE;
          cnt_d   = '0;
        end
      end
      S_SAVE: begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: begin
        cnt_d = '0;
`ifdef SIMECK_SEQ_BACKPRESSURE_EN
        if (done_ready) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // save comes from its own flop so the datapath sees a glitch-free edge
    save_d = (state_d == S_SAVE);
  end

  always_comb begin
    start_ready   = 1'b0;
    shiftregReset = 1'b0;
    lfsrset       = 1'b0;
    dctr          = 1'b0;
    kctr          = 1'b0;
    done_valid    = 1'b0;
    data          = '0;
    key           = '0;
    round         = '0;
    case (state_q)
      S_IDLE: begin
        start_ready   = 1'b1;
        shiftregReset = 1'b1;
      end
      S_LOAD: begin
        lfsrset = 1'b1;
        if (cnt_q == '0)            data = pt_q[2*DATAW-1:DATAW];
        else if (cnt_q == CW'(1))   data = pt_q[DATAW-1:0];
        for (int k = 0; k < KEYWORDS; k++)
          if (cnt_q == CW'(k)) key = key_q[k*DATAW +: DATAW];
      end
      S_RUN: begin
        dctr  = 1'b1;
        kctr  = 1'b1;
        round = RW'(cnt_q);
      end
      S_SAVE: begin
        dctr = 1'b1;
        kctr = 1'b1;
      end
      S_DONE: done_valid = 1'b1;
      default: ;
    endcase
  end

  assign save = save_q;

endmodule
